tanh_requester: RTL

Request-side controller for the iterative Q5.26 hyperbolic-tangent unit. It accepts operands on a valid/ready stream and drives the unit's operand/wait/complete/lock handshake. It collects each result, clamps it to ±1.0, and queues it in a small result FIFO for a downstream valid/ready consumer. It sits between the activation-layer datapath and the tanh unit, and recovers the unit with a lock pulse if it stalls.

---
 rtl/tanh_pkg.sv | 18 +
 rtl/tanh_result_fifo.sv | 44 ++++
 rtl/tanh_requester.sv | 129 ++++++++++++
 3 files changed

// File: rtl/tanh_pkg.sv
// Shared Q5.26 format constants and controller state encoding for the tanh request path.
package tanh_pkg;

    localparam int WORD      = 32;
    localparam int FRAC_BITS = 26;

    localparam logic [WORD-1:0] TANH_ONE     = WORD'(1) << FRAC_BITS;
    localparam logic [WORD-1:0] TANH_NEG_ONE = -TANH_ONE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RELEASE,
        ST_WAIT_EN,
        ST_ACK,
        ST_ABORT
    } tanh_state_t;

endpackage

// File: rtl/tanh_result_fifo.sv
// First-word-fall-through result FIFO; extra pointer bit separates full from empty.
module tanh_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_rd;

    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A write while full only happens alongside a read, so the old head is read out first.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tanh_requester.sv
// Request-side controller for the iterative tanh unit: operand release, result capture
// with clamping to +/-1.0, timeout abort via lock pulse, and a small result queue.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | waiting for an operand; accepts when the queue has room
//   ST_RELEASE | wa held low WA_LOW cycles so the unit samples oz
//   ST_WAIT_EN | waiting for en; timer guards against a stalled unit
//   ST_ACK     | comp held until the unit drops en
//   ST_ABORT   | locked pulsed for two cycles, then an error entry is queued
module tanh_requester
    import tanh_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int WA_LOW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] in_data,
    output logic [WORD-1:0] oz,
    output logic            wa,
    output logic            comp,
    output logic            locked,
    input  logic            en,
    input  logic [WORD-1:0] tanh,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] out_data,
    output logic            out_err,
    output logic            busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 2);

    tanh_state_t     state;
    tanh_state_t     state_nx;
    logic [TW-1:0]   timer;
    logic [WORD-1:0] clamped;
    logic            accept;
    logic            fifo_wr;
    logic [WORD:0]   fifo_wdata;
    logic [WORD:0]   fifo_rdata;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;

    // A free slot is reserved at accept, so the eventual capture or error write never overflows.
    assign in_ready = !rst && (state == ST_IDLE) && (fifo_count < CW'(DEPTH));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            timer <= '0;
            oz    <= '0;
        end else begin
            state <= state_nx;
            if (accept) oz <= in_data;
            if (state == ST_IDLE || state == ST_ACK) timer <= '0;
            else                                     timer <= timer + 1'b1;
        end
    end

    always_comb begin
        if ($signed(tanh) > $signed(TANH_ONE))          clamped = TANH_ONE;
        else if ($signed(tanh) < $signed(TANH_NEG_ONE)) clamped = TANH_NEG_ONE;
        else                                            clamped = tanh;
    end

    always_comb begin
        state_nx   = state;
        fifo_wr    = 1'b0;
        fifo_wdata = {1'b0, clamped};
        case (state)
            ST_IDLE: begin
                if (accept) state_nx = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (timer == TW'(WA_LOW - 1)) state_nx = ST_WAIT_EN;
            end
            ST_WAIT_EN: begin
                if (en) begin
                    fifo_wr  = 1'b1;
                    state_nx = ST_ACK;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nx = ST_ABORT;
                end
            end
            ST_ACK: begin
                if (!en) state_nx = ST_IDLE;
            end
            ST_ABORT: begin
                if (timer == TW'(TIMEOUT + 1)) begin
                    fifo_wr    = 1'b1;
                    fifo_wdata = {1'b1, {WORD{1'b0}}};
                    state_nx   = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign wa     = (state != ST_RELEASE);
    assign comp   = (state == ST_ACK);
    assign locked = (state == ST_ABORT);
    assign busy   = (state != ST_IDLE);

    tanh_result_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (out_ready),
        .rd_data (fifo_rdata),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_rdata[WORD-1:0];
    assign out_err   = !fifo_empty && fifo_rdata[WORD];

endmodule
